gamepad_multi_viz: RTL and testbench



---
 rtl/gamepad_viz_pkg.sv | 61 ++++++
 rtl/gamepad_glyph_rom.sv | 30 +++
 rtl/gamepad_multi_viz.sv | 174 +++++++++++++++++
 tb/tb_gamepad_multi_viz.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gamepad_viz_pkg.sv
// Shared constants for the gamepad renderer: button indices, colours and the
// glyph layout, with positions in glyph units (one glyph unit is SCALE screen pixels).
package gamepad_viz_pkg;

    localparam int NUM_BTN = 12;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    localparam logic [5:0] COL_BLACK    = 6'b000000;
    localparam logic [5:0] COL_DARK_RED = 6'b010000;
    localparam logic [5:0] COL_GREEN    = 6'b001100;
    localparam logic [5:0] COL_WHITE    = 6'b111111;

    function automatic logic [9:0] glyph_x(input logic [3:0] g);
        case (g)
            4'd0:  glyph_x = 10'd128;
            4'd1:  glyph_x = 10'd116;
            4'd2:  glyph_x = 10'd66;
            4'd3:  glyph_x = 10'd82;
            4'd4:  glyph_x = 10'd24;
            4'd5:  glyph_x = 10'd24;
            4'd6:  glyph_x = 10'd12;
            4'd7:  glyph_x = 10'd36;
            4'd8:  glyph_x = 10'd140;
            4'd9:  glyph_x = 10'd128;
            4'd10: glyph_x = 10'd8;
            4'd11: glyph_x = 10'd148;
            default: glyph_x = 10'd1000;
        endcase
    endfunction

    function automatic logic [9:0] glyph_y(input logic [3:0] g);
        case (g)
            4'd0:  glyph_y = 10'd74;
            4'd1:  glyph_y = 10'd60;
            4'd2:  glyph_y = 10'd60;
            4'd3:  glyph_y = 10'd60;
            4'd4:  glyph_y = 10'd48;
            4'd5:  glyph_y = 10'd72;
            4'd6:  glyph_y = 10'd60;
            4'd7:  glyph_y = 10'd60;
            4'd8:  glyph_y = 10'd60;
            4'd9:  glyph_y = 10'd46;
            4'd10: glyph_y = 10'd23;
            4'd11: glyph_y = 10'd23;
            default: glyph_y = 10'd1000;
        endcase
    endfunction

endpackage

// File: rtl/gamepad_glyph_rom.sv
// Combinational 8x8 bitmap ROM for the 12 gamepad glyphs; bit 7 of a row is the
// leftmost column, row 0 is the top row.
module gamepad_glyph_rom (
    input  logic [3:0] glyph,
    input  logic [2:0] row,
    output logic [7:0] bits
);
    logic [63:0] bm;

    // Each constant lists rows 0..7 from the most significant byte down.
    always_comb begin
        bm = 64'h0;
        case (glyph)
            4'd0:  bm = 64'h7C66667C66667C00; // B
            4'd1:  bm = 64'h6666663C18181800; // Y
            4'd2:  bm = 64'h00007E7E7E000000; // select
            4'd3:  bm = 64'h4060707870604000; // start
            4'd4:  bm = 64'h183C7EFF18181800; // up
            4'd5:  bm = 64'h181818FF7E3C1800; // down
            4'd6:  bm = 64'h10307FFF7F301000; // left
            4'd7:  bm = 64'h080CFEFFFE0C0800; // right
            4'd8:  bm = 64'h386CC6C6FEC6C600; // A
            4'd9:  bm = 64'hC66C38386CC6C600; // X
            4'd10: bm = 64'h6060606060627E00; // L
            4'd11: bm = 64'h7C66667C6C666600; // R
            default: bm = 64'h0;
        endcase
        bits = bm[{~row, 3'b000} +: 8];
    end
endmodule

// File: rtl/gamepad_multi_viz.sv
// Two-stage raster renderer drawing one 12-glyph gamepad layout per player.
// Define GAMEPAD_VIZ_FADE_EN to build per-button release fade counters.
module gamepad_multi_viz
    import gamepad_viz_pkg::*;
#(
    parameter int SCALE        = 4,
    parameter int N_PLAYERS    = 1,
    parameter int PLAYER_PITCH = 240,
    parameter int FADE_W       = 4,
    parameter int TICK_LINE    = 480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [9:0]              pix_x,
    input  logic [9:0]              pix_y,
    input  logic                    video_active,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic [12*N_PLAYERS-1:0] buttons,
    input  logic [N_PLAYERS-1:0]    present,
    output logic [5:0]              rgb,
    output logic                    hsync_out,
    output logic                    vsync_out
);
    localparam int SH = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;

    if (!(SCALE == 1 || SCALE == 2 || SCALE == 4) || !(N_PLAYERS == 1 || N_PLAYERS == 2) ||
        (N_PLAYERS == 2 && SCALE > 2) || FADE_W < 2 || TICK_LINE < 0 || TICK_LINE > 1023)
    begin : g_bad_cfg
        $error("gamepad_multi_viz: illegal SCALE/N_PLAYERS/FADE_W/TICK_LINE configuration");
    end

    // ---- S1: player select, glyph-unit coordinates, hit detection
    logic        p_c, pres_c;
    logic [9:0]  ux_c, uy_c, dx, dy;
    logic [23:0] btn_all;
    logic [1:0]  pres_all;
    logic [11:0] btn_c, hit_c;
    logic [2:0]  col_c, row_c;

    assign btn_all  = 24'(buttons);
    assign pres_all = 2'(present);
    assign p_c      = (N_PLAYERS == 2) && (pix_y >= 10'(PLAYER_PITCH));
    assign ux_c     = pix_x >> SH;
    assign uy_c     = (pix_y - (p_c ? 10'(PLAYER_PITCH) : 10'd0)) >> SH;
    assign btn_c    = p_c ? btn_all[23:12] : btn_all[11:0];
    assign pres_c   = p_c ? pres_all[1] : pres_all[0];

    // Unsigned offset wraps high when left of / above the box, so one compare covers both ends.
    always_comb begin
        hit_c = '0;
        col_c = '0;
        row_c = '0;
        dx    = '0;
        dy    = '0;
        for (int g = 0; g < NUM_BTN; g++) begin
            dx = ux_c - glyph_x(4'(g));
            dy = uy_c - glyph_y(4'(g));
            if (dx < 10'd8 && dy < 10'd8) begin
                hit_c[g] = 1'b1;
                col_c    = dx[2:0];
                row_c    = dy[2:0];
            end
        end
    end

    logic        p_q, act_q, hs_q, vs_q, pres_q;
    logic [11:0] hit_q, eff_q;
    logic [2:0]  col_q, row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= 1'b0;
            act_q  <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            pres_q <= 1'b0;
            hit_q  <= '0;
            eff_q  <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else begin
            p_q    <= p_c;
            act_q  <= video_active;
            hs_q   <= hsync_in;
            vs_q   <= vsync_in;
            pres_q <= pres_c;
            hit_q  <= hit_c;
            eff_q  <= btn_c & {12{pres_c}};
            col_q  <= col_c;
            row_q  <= row_c;
        end
    end

    // ---- fade counters (top two bits per player/button, zero when not built)
    logic [1:0][NUM_BTN-1:0][1:0] fade_k;

`ifdef GAMEPAD_VIZ_FADE_EN
    logic              tick;
    logic [FADE_W-1:0] fade_cnt [N_PLAYERS][NUM_BTN];

    assign tick = (pix_x == 10'd0) && (pix_y == 10'(TICK_LINE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PLAYERS; i++)
                for (int j = 0; j < NUM_BTN; j++)
                    fade_cnt[i][j] <= '0;
        end else begin
            for (int i = 0; i < N_PLAYERS; i++)
                for (int j = 0; j < NUM_BTN; j++)
                    if (!present[i])
                        fade_cnt[i][j] <= '0;
                    else if (buttons[12*i+j])
                        fade_cnt[i][j] <= '1;
                    else if (tick && fade_cnt[i][j] != '0)
                        fade_cnt[i][j] <= fade_cnt[i][j] - FADE_W'(1);
        end
    end

    always_comb begin
        fade_k = '0;
        for (int i = 0; i < N_PLAYERS; i++)
            for (int j = 0; j < NUM_BTN; j++)
                fade_k[i][j] = fade_cnt[i][j][FADE_W-1 -: 2];
    end
`else
    assign fade_k = '0;
`endif

    // ---- S2: ROM lookup and colour
    logic [3:0] gidx;
    logic [7:0] rom_bits;
    logic [1:0] k;
    logic       pix_on;
    logic [5:0] rgb_c;

    always_comb begin
        gidx = '0;
        for (int g = 0; g < NUM_BTN; g++)
            if (hit_q[g]) gidx = 4'(g);
    end

    gamepad_glyph_rom u_rom (
        .glyph (gidx),
        .row   (row_q),
        .bits  (rom_bits)
    );

    assign pix_on = act_q && (|hit_q) && rom_bits[~col_q];
    assign k      = fade_k[p_q][gidx];

    always_comb begin
        rgb_c = COL_BLACK;
        if (pix_on) begin
            if (!pres_q)            rgb_c = COL_DARK_RED;
            else if (eff_q[gidx])   rgb_c = COL_GREEN;
            else if (k != 2'd0)     rgb_c = {2'b00, k, 2'b00};
            else                    rgb_c = COL_WHITE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb       <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            rgb       <= rgb_c;
            hsync_out <= hs_q;
            vsync_out <= vs_q;
        end
    end
endmodule

// File: tb/tb_gamepad_multi_viz.sv
// Scoreboard bench: dut1 uses the default build (SCALE=4, one pad), dut2 uses
// SCALE=2 with two pads; both are compared against a pixel-level reference model.
module tb_gamepad_multi_viz;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pix_x = '0, pix_y = '0;
    logic        video_active = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [23:0] buttons = '0;
    logic [1:0]  present = 2'b11;
    logic [5:0]  rgb1, rgb2;
    logic        hs1, vs1, hs2, vs2;

    logic [23:0] btn_next = '0;
    logic [1:0]  pres_next = 2'b11;

    always #5 clk = ~clk;

    gamepad_multi_viz dut1 (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .video_active(video_active), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .buttons(buttons[11:0]), .present(present[0]),
        .rgb(rgb1), .hsync_out(hs1), .vsync_out(vs1)
    );

    gamepad_multi_viz #(.SCALE(2), .N_PLAYERS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .video_active(video_active), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .buttons(buttons), .present(present),
        .rgb(rgb2), .hsync_out(hs2), .vsync_out(vs2)
    );

    // Glyph bitmaps, row 0 in the top byte; bit (63 - 8*row - col) is pixel (col,row).
    localparam logic [63:0] BM [12] = '{
        64'h7C66667C66667C00, 64'h6666663C18181800, 64'h00007E7E7E000000, 64'h4060707870604000,
        64'h183C7EFF18181800, 64'h181818FF7E3C1800, 64'h10307FFF7F301000, 64'h080CFEFFFE0C0800,
        64'h386CC6C6FEC6C600, 64'hC66C38386CC6C600, 64'h6060606060627E00, 64'h7C66667C6C666600};
    localparam int GX [12] = '{128, 116, 66, 82, 24, 24, 12, 36, 140, 128, 8, 148};
    localparam int GY [12] = '{74, 60, 60, 60, 48, 72, 60, 60, 60, 46, 23, 23};

    int fade [2][2][12];   // [dut][player][button]
    int cyc = 0, total = 0, bad = 0;

    typedef struct {
        int         due;
        logic [5:0] r1, r2;
        logic       hs, vs;
    } exp_t;
    exp_t q[$];

    function automatic logic [5:0] model_rgb(int d, int sc, int np, int x, int y, bit act);
        int p, ux, uy, c, r, k;
        if (!act) return 6'b0;
        p  = (np == 2 && y >= 240) ? 1 : 0;
        ux = x / sc;
        uy = (y - 240 * p) / sc;
        for (int g = 0; g < 12; g++) begin
            if (ux >= GX[g] && ux < GX[g] + 8 && uy >= GY[g] && uy < GY[g] + 8) begin
                c = ux - GX[g];
                r = uy - GY[g];
                if (!BM[g][63 - 8*r - c]) return 6'b0;
                if (!present[p]) return 6'b010000;
                if (buttons[12*p + g]) return 6'b001100;
`ifdef GAMEPAD_VIZ_FADE_EN
                k = fade[d][p][g] / 4;
`else
                k = 0;
`endif
                if (k != 0) return {2'b00, k[1:0], 2'b00};
                return 6'b111111;
            end
        end
        return 6'b0;
    endfunction

    task automatic model_step(int x, int y);
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < d + 1; p++)
                for (int g = 0; g < 12; g++)
                    if (!present[p])               fade[d][p][g] = 0;
                    else if (buttons[12*p + g])    fade[d][p][g] = 15;
                    else if (x == 0 && y == 480 && fade[d][p][g] > 0) fade[d][p][g]--;
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                for (int g = 0; g < 12; g++)
                    fade[d][p][g] = 0;
    endtask

    task automatic chk(string name, logic [5:0] got, logic [5:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b cyc=%0d", name, got, want, cyc);
        end
    endtask

    // One pixel cycle: inputs change on the falling edge, expectation due two rising edges later.
    task automatic drive(int x, int y, bit act, bit hs, bit vs, bit rel);
        exp_t e;
        @(negedge clk);
        if (rel) begin
            rst_n = 1'b1;
            e.due = cyc + 1; e.r1 = '0; e.r2 = '0; e.hs = 1'b0; e.vs = 1'b0;
            q.push_back(e);
        end
        buttons = btn_next;
        present = pres_next;
        pix_x = 10'(x); pix_y = 10'(y);
        video_active = act; hsync_in = hs; vsync_in = vs;
        model_step(x, y);
        e.due = cyc + 2;
        e.r1  = model_rgb(0, 4, 1, x, y, act);
        e.r2  = model_rgb(1, 2, 2, x, y, act);
        e.hs  = hs;
        e.vs  = vs;
        q.push_back(e);
    endtask

    task automatic drv(int x, int y, bit act);
        drive(x, y, act, 1'($urandom % 2), 1'($urandom % 2), 1'b0);
    endtask

    // Assert reset between edges while a green A pixel is on screen, then release.
    task automatic reset_check(string tag);
        btn_next[8] = 1'b1;
        pres_next = 2'b11;
        repeat (3) drive(568, 240, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_rgb1"}, rgb1, 6'b0);
        chk({tag, "_rgb2"}, rgb2, 6'b0);
        chk({tag, "_syncs"}, {4'b0, hs1, vs1}, 6'b0);
        model_clear();
        repeat (2) @(posedge clk);
        drive(568, 240, 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                if (e.due < cyc) begin
                    total++; bad++;
                    $display("FAIL late_entry due=%0d now=%0d", e.due, cyc);
                end else begin
                    chk("rgb1", rgb1, e.r1);
                    chk("rgb2", rgb2, e.r2);
                    chk("sync1", {4'b0, hs1, vs1}, {4'b0, e.hs, e.vs});
                    chk("sync2", {4'b0, hs2, vs2}, {4'b0, e.hs, e.vs});
                end
            end
        end
    end

    initial begin : stim
        int x, y, g, sc, pl;
        // Reset held from time 0 with a green A pixel presented.
        btn_next[8] = 1'b1;
        buttons = btn_next;
        pix_x = 10'd568; pix_y = 10'd240; video_active = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rgb1", rgb1, 6'b0);
        chk("reset_rgb2", rgb2, 6'b0);
        chk("reset_syncs", {2'b0, hs1, vs1, hs2, vs2}, 6'b0);
        drive(568, 240, 1'b1, 1'b1, 1'b1, 1'b1);

        // Press, then neighbour pixel with a clear bitmap bit.
        drv(568, 240, 1'b1);
        drv(560, 240, 1'b1);
        // Release and fade through ticks, then a press landing on a tick.
        btn_next[8] = 1'b0;
        drv(568, 240, 1'b1);
        repeat (4) drv(0, 480, 1'b1);
        drv(568, 240, 1'b1);
        repeat (8) drv(0, 480, 1'b1);
        drv(568, 240, 1'b1);
        btn_next[8] = 1'b1;
        drv(0, 480, 1'b1);
        btn_next[8] = 1'b0;
        drv(568, 240, 1'b1);
        // Absent pad with a held, then present again with nothing pressed.
        btn_next[8] = 1'b1;
        pres_next = 2'b00;
        drv(568, 240, 1'b1);
        drv(258, 388, 1'b1);
        pres_next = 2'b11;
        btn_next = '0;
        drv(568, 240, 1'b1);
        // Two-player layout: player1 b pressed, player0 b idle.
        btn_next[12] = 1'b1;
        drv(258, 388, 1'b1);
        drv(258, 148, 1'b1);
        // Blanking suppresses colour.
        drv(568, 240, 1'b0);
        drv(258, 388, 1'b0);

        reset_check("midreset");

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 29) == 0) btn_next = btn_next ^ (24'd1 << $urandom_range(0, 23));
            if ($urandom_range(0, 59) == 0)
                pres_next = ($urandom_range(0, 2) == 0) ? 2'($urandom % 4) : 2'b11;
            if ($urandom_range(0, 9) == 0) begin
                drv(0, 480, 1'b1);
            end else begin
                g = int'($urandom_range(0, 11));
                if ($urandom % 2 == 0) begin sc = 4; pl = 0; end
                else begin sc = 2; pl = int'($urandom % 2); end
                x = (GX[g] + int'($urandom_range(0, 11)) - 2) * sc + int'($urandom_range(0, sc - 1));
                y = (GY[g] + int'($urandom_range(0, 11)) - 2) * sc + pl * 240 +
                    int'($urandom_range(0, sc - 1));
                drv(x, y, $urandom_range(0, 9) != 0);
            end
        end

        repeat (4) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
